// File: rtl/fifo_read_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_read_serializer_pkg
// Shared definitions for the FIFO read-side serializer:
//   - FSM state encoding (IDLE / POP / LOAD / SEND)
//   - helpers that derive the beat count per word and the beat counter width
// Imported by the serializer RTL and by its testbench.
// -----------------------------------------------------------------------------
package fifo_read_serializer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_POP  = 2'd1;
  localparam state_t ST_LOAD = 2'd2;
  localparam state_t ST_SEND = 2'd3;

  // Number of OUT_WIDTH beats carried by one DATA_WIDTH word.
  function automatic int calc_beats(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  // Beat counter width: clog2(beats), never less than one bit.
  function automatic int calc_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/fifo_read_serializer.sv
// -----------------------------------------------------------------------------
// fifo_read_serializer
// Drains a synchronous FIFO one word at a time and streams each word out as
// DATA_WIDTH/OUT_WIDTH beats on a valid/ready interface.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   enable         permission to start popping new words
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid the cycle after a pop
//   fifo_cs        FIFO chip select (high only in POP)
//   fifo_rd_en     FIFO read enable (high only in POP)
//   out_valid      beat valid
//   out_ready      downstream ready
//   out_data       current beat
//   out_last       final beat of the current word
//   busy           high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module fifo_read_serializer
  import fifo_read_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int BEATS = calc_beats(DATA_WIDTH, OUT_WIDTH);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  start_ok;
  logic                  xfer;
  logic                  last_beat;
  logic [OUT_WIDTH-1:0]  head;

  assign start_ok  = enable && !fifo_empty;
  assign xfer      = (state_q == ST_SEND) && out_ready;
  assign last_beat = (cnt_q == LAST_CNT);

  // The beat on the wire is always the slice at the send end of the shift
  // register; shifting toward that end exposes the next slice.
  assign head = MSB_FIRST ? shift_q[DATA_WIDTH-1 -: OUT_WIDTH]
                          : shift_q[OUT_WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_POP;
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        // Chaining straight into POP on the final beat keeps throughput at
        // BEATS+2 cycles per word.
        if (xfer && last_beat) begin
          state_d = start_ok ? ST_POP : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the state directly so the FIFO sees cs/rd_en in the same
  // cycle the FSM is in POP.
  always_comb begin
    fifo_cs    = (state_q == ST_POP);
    fifo_rd_en = (state_q == ST_POP);
    out_valid  = (state_q == ST_SEND);
    out_last   = (state_q == ST_SEND) && last_beat;
    out_data   = (state_q == ST_SEND) ? head : '0;
    busy       = (state_q != ST_IDLE);
  end

  // Shift register and beat counter next-state
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == ST_LOAD) begin
      shift_d = fifo_data_out;
      cnt_d   = '0;
    end else if (xfer && !last_beat) begin
      shift_d = MSB_FIRST ? (shift_q << OUT_WIDTH) : (shift_q >> OUT_WIDTH);
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_serializer
// Directed bench for fifo_read_serializer. A small FIFO model feeds two
// instances (MSB-first and LSB-first) that share every input; monitors log
// each accepted beat and each pop on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_read_serializer;
  import fifo_read_serializer_pkg::*;

  localparam int DW = 32;
  localparam int OW = 8;
  localparam int BEATS = calc_beats(DW, OW);

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          out_ready;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;

  logic          cs_a, rd_a, vld_a, last_a, busy_a;
  logic [OW-1:0] data_a;
  logic          cs_b, rd_b, vld_b, last_b, busy_b;
  logic [OW-1:0] data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_read_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_dout), .fifo_cs(cs_a), .fifo_rd_en(rd_a),
    .out_valid(vld_a), .out_ready(out_ready), .out_data(data_a),
    .out_last(last_a), .busy(busy_a)
  );

  fifo_read_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_dout), .fifo_cs(cs_b), .fifo_rd_en(rd_b),
    .out_valid(vld_b), .out_ready(out_ready), .out_data(data_b),
    .out_last(last_b), .busy(busy_b)
  );

  // FIFO model: the bench writes, the MSB-first instance reads.
  logic [DW-1:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_a && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors
  logic [OW-1:0] bd_a [0:63];
  logic          bl_a [0:63];
  int            bc_a [0:63];
  int            nb_a = 0;
  logic [OW-1:0] bd_b [0:63];
  logic          bl_b [0:63];
  int            nb_b = 0;
  int            pop_cyc [0:63];
  int            npop = 0;
  int            bad_pop = 0;
  int            vcnt = 0;

  always @(negedge clk) begin
    if (vld_a && out_ready && nb_a < 64) begin
      bd_a[nb_a] = data_a;
      bl_a[nb_a] = last_a;
      bc_a[nb_a] = cyc;
      nb_a++;
    end
    if (vld_b && out_ready && nb_b < 64) begin
      bd_b[nb_b] = data_b;
      bl_b[nb_b] = last_b;
      nb_b++;
    end
    if (vld_a) vcnt++;
    if (rd_a && npop < 64) begin
      pop_cyc[npop] = cyc;
      npop++;
    end
    if ((rd_a || cs_a) && fifo_empty) bad_pop++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_beats_a(input int target, input int budget);
    int g;
    g = 0;
    while (nb_a < target && g < budget) begin
      @(posedge clk);
      g++;
    end
    chk("beat_timeout_a", 32'(nb_a >= target), 32'd1);
  endtask

  task automatic wait_beats_b(input int target, input int budget);
    int g;
    g = 0;
    while (nb_b < target && g < budget) begin
      @(posedge clk);
      g++;
    end
    chk("beat_timeout_b", 32'(nb_b >= target), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, p0, v0, g;
    logic [7:0] exp4 [0:3];
    logic [7:0] exp8 [0:7];

    rst = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;

    // Reset state
    idle_cycles(3);
    chk("rst_cs", 32'(cs_a), 0);
    chk("rst_rd_en", 32'(rd_a), 0);
    chk("rst_valid", 32'(vld_a), 0);
    chk("rst_last", 32'(last_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_data", 32'(data_a), 0);
    rst = 1'b1;
    idle_cycles(2);

    // Single word, no stall, MSB first
    b0 = nb_a; p0 = npop;
    push(32'h11223344);
    enable = 1'b1;
    out_ready = 1'b1;
    wait_beats_a(b0 + BEATS, 50);
    idle_cycles(3);
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("single_beat%0d", k), 32'(bd_a[b0+k]), 32'(exp4[k]));
      chk($sformatf("single_last%0d", k), 32'(bl_a[b0+k]), 32'(k == 3));
    end
    for (int k = 1; k < 4; k++)
      chk($sformatf("single_gap%0d", k), 32'(bc_a[b0+k] - bc_a[b0+k-1]), 1);
    chk("single_latency", 32'(bc_a[b0] - pop_cyc[p0]), 2);
    chk("single_pops", 32'(npop - p0), 1);
    chk("single_busy_end", 32'(busy_a), 0);

    // Backpressure: ready low for 3 cycles once the first beat is shown
    out_ready = 1'b0;
    b0 = nb_a; p0 = npop;
    push(32'h11223344);
    g = 0;
    while (!vld_a && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_valid%0d", k), 32'(vld_a), 1);
      chk($sformatf("stall_data%0d", k), 32'(data_a), 32'h11);
      chk($sformatf("stall_last%0d", k), 32'(last_a), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_beats_a(b0 + BEATS, 50);
    idle_cycles(3);
    chk("stall_count", 32'(nb_a - b0), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("stall_beat%0d", k), 32'(bd_a[b0+k]), 32'(exp4[k]));
    chk("stall_pops", 32'(npop - p0), 1);

    // Back-to-back words
    b0 = nb_a; p0 = npop;
    push(32'h00000001);
    push(32'h00000002);
    wait_beats_a(b0 + 2*BEATS, 100);
    idle_cycles(10);
    exp8 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    for (int k = 0; k < 8; k++)
      chk($sformatf("b2b_beat%0d", k), 32'(bd_a[b0+k]), 32'(exp8[k]));
    chk("b2b_last_first", 32'(bl_a[b0+3]), 1);
    chk("b2b_last_second", 32'(bl_a[b0+7]), 1);
    chk("b2b_pops", 32'(npop - p0), 2);
    chk("b2b_pop_gap", 32'(pop_cyc[p0+1] - pop_cyc[p0]), 32'(BEATS + 2));
    chk("b2b_empty", 32'(fifo_empty), 1);
    chk("b2b_extra_beats", 32'(nb_a - b0), 8);

    // Empty FIFO with enable held high
    p0 = npop; v0 = vcnt;
    idle_cycles(20);
    chk("empty_pops", 32'(npop - p0), 0);
    chk("empty_valid", 32'(vcnt - v0), 0);
    chk("empty_busy", 32'(busy_a), 0);

    // Reset in the middle of a word
    b0 = nb_a;
    push(32'hAABBCCDD);
    g = 0;
    while (nb_a < b0 + 2 && g < 50) begin
      @(posedge clk);
      g++;
    end
    chk("mid_two_beats", 32'(nb_a - b0), 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vld_a), 0);
    chk("mid_rst_data", 32'(data_a), 0);
    chk("mid_rst_last", 32'(last_a), 0);
    chk("mid_rst_busy", 32'(busy_a), 0);
    chk("mid_rst_rd_en", 32'(rd_a), 0);
    chk("mid_rst_cs", 32'(cs_a), 0);
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(10);
    chk("mid_beat0", 32'(bd_a[b0]), 32'hAA);
    chk("mid_beat1", 32'(bd_a[b0+1]), 32'hBB);
    chk("mid_no_more", 32'(nb_a - b0), 2);
    chk("mid_idle", 32'(busy_a), 0);

    // LSB-first instance
    b0 = nb_b;
    push(32'hAABBCCDD);
    wait_beats_b(b0 + BEATS, 50);
    idle_cycles(3);
    exp4 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lsb_beat%0d", k), 32'(bd_b[b0+k]), 32'(exp4[k]));
      chk($sformatf("lsb_last%0d", k), 32'(bl_b[b0+k]), 32'(k == 3));
    end
    chk("lsb_busy_end", 32'(busy_b), 0);

    chk("never_pop_empty", 32'(bad_pop), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_serializer.md
Name: fifo_read_serializer

Overview:
- Downstream drain stage for the synchronous FIFO (ports cs/rd_en/data_out/empty).
- Pops one DATA_WIDTH word at a time and slices it into OUT_WIDTH beats on a valid/ready stream toward the next consumer, for example a byte-wide transmitter.
- Owns the FIFO read side completely; no other agent drives the FIFO's cs or rd_en.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH
OUT_WIDTH, 8, output beat width
MSB_FIRST, 1, 1 = most-significant slice sent first; 0 = least-significant first

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-low reset
enable  input  1  1 = allowed to start popping new words
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  DATA_WIDTH  FIFO read data; valid in the cycle after a pop cycle
fifo_cs  output  1  FIFO chip select; high only in POP
fifo_rd_en  output  1  FIFO read enable; high only in POP
out_valid  output  1  beat valid
out_ready  input  1  downstream accepts a beat when high together with out_valid
out_data  output  OUT_WIDTH  current beat
out_last  output  1  high with the final beat of a word
busy  output  1  high in any state other than IDLE

Behaviour:
- Derived constant: BEATS = DATA_WIDTH/OUT_WIDTH. BEATS = 1 is legal: a single beat carries the whole word.
- Reset (rst low, asynchronous):
  - state = IDLE; shift register and beat counter cleared.
  - fifo_cs, fifo_rd_en, out_valid, out_last, busy all 0; out_data = 0.
  - Any word in flight is discarded. It has already left the FIFO, so the loss is accepted.
- FSM states: IDLE, POP, LOAD, SEND.
  - IDLE: if enable && !fifo_empty, go to POP; otherwise stay.
  - POP, exactly 1 cycle: fifo_cs = 1 and fifo_rd_en = 1, driven as combinational decodes of the state with no extra register stage. The FIFO registers data_out on this edge. Next state LOAD.
  - LOAD, 1 cycle: shift register <= fifo_data_out at the end of the cycle; beat counter <= 0. Next state SEND.
  - SEND: out_valid = 1.
    - out_data = shift register bits [DATA_WIDTH-1 -: OUT_WIDTH] when MSB_FIRST = 1, otherwise bits [OUT_WIDTH-1:0].
    - out_last = 1 when beat counter == BEATS-1.
- Handshake:
  - A beat transfers on a rising edge with out_valid && out_ready.
  - While out_ready is low, out_data, out_last and out_valid hold stable. No beat is dropped or repeated.
  - On a non-final transfer: shift by OUT_WIDTH toward the send end, zero-fill the vacated slice, increment the beat counter.
  - On the final transfer (out_last):
    - if enable && !fifo_empty, go directly to POP;
    - otherwise go to IDLE.
- Latency and throughput:
  - fifo_empty falling (with enable high) while IDLE -> fifo_rd_en high on the next cycle -> first out_valid 2 cycles after the POP cycle.
  - Sustained throughput: BEATS+2 cycles per word with out_ready held high.
- Boundary conditions:
  - Never pops when fifo_empty = 1. fifo_empty is sampled only in IDLE and on the final transfer.
  - enable falling mid-word: the current word completes, then the block returns to IDLE.
  - enable toggles are ignored in POP and LOAD.
  - fifo_data_out is ignored outside LOAD.
  - out_ready high outside SEND has no effect.
  - Beat counter width: clog2(BEATS), minimum 1. It never exceeds BEATS-1.

Decomposition:
- Shared package: state encoding (IDLE/POP/LOAD/SEND localparams) and the BEATS/counter-width computation, reused by the bench scoreboard.
- Single module; no sub-module needed. Shift register, counter and FSM are all in one file.

Test Plan:
- Single word, no stall, MSB_FIRST=1: write 0x11223344, enable=1, out_ready=1 -> rd_en pulses once; beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles; out_last only with 0x44; busy returns to 0.
- Backpressure: same word, out_ready low for 3 cycles after the first beat is presented -> out_data holds 0x11 with valid high throughout; still exactly 4 beats total, in order.
- Back-to-back: FIFO holds 0x00000001 and 0x00000002 -> two rd_en pulses separated by 6 cycles; beats 00,00,00,01,00,00,00,02; fifo_empty high afterwards and no further rd_en.
- Empty FIFO with enable=1 for 20 cycles -> fifo_rd_en and fifo_cs never assert; out_valid stays 0.
- Reset mid-word: rst low after the second beat of 0xAABBCCDD -> all outputs 0 immediately (asynchronous); after release, no beat 0xCC is emitted and state is IDLE.
- MSB_FIRST=0, word 0xAABBCCDD -> beats DD, CC, BB, AA; out_last with AA.
